// File: rtl/saida_display_if.sv
// Processor OUT-port to seven-segment display bus.
// master = processor side, slave = saida_display.
interface saida_display_if;
    logic        Escrever;
    logic [15:0] Dado;
    logic        Ocupado;
    logic        Pronto;
    logic [6:0]  Hex0;
    logic [6:0]  Hex1;
    logic [6:0]  Hex2;
    logic [6:0]  Hex3;
    logic [6:0]  Hex4;
    logic [6:0]  Hex5;

    modport master (
        output Escrever, Dado,
        input  Ocupado, Pronto,
        input  Hex0, Hex1, Hex2, Hex3, Hex4, Hex5
    );

    modport slave (
        input  Escrever, Dado,
        output Ocupado, Pronto,
        output Hex0, Hex1, Hex2, Hex3, Hex4, Hex5
    );
endinterface

// File: rtl/saida_display.sv
// 16-bit value to six active-low seven-segment displays via double dabble.
// Define SAIDA_SIGNED_EN to treat Dado as two's complement with a sign display.
module saida_display #(
    parameter bit LEADING_ZERO_BLANK = 1'b1
) (
    input logic           Clock,
    input logic           Reset,
    saida_display_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic [6:0] SEG_RST   =
        LEADING_ZERO_BLANK ? SEG_BLANK : SEG_ZERO;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] mag;
    logic [19:0] bcd;
    logic [4:0]  cnt;
    logic        sign;
    logic        hold;

    logic [19:0] bcd_adj;
    logic [19:0] bcd_shift;
    logic [4:0]  nz;
    logic [4:0]  show;
    logic [6:0]  seg [5];

    logic [15:0] cap_mag;
    logic [19:0] cap_bcd;
    logic        cap_sign;
    logic        cap_hold;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Value captured at acceptance: magnitude, sign and BCD preload
`ifdef SAIDA_SIGNED_EN
    logic        neg;
    logic [15:0] abs_val;
    logic        is_min;

    always_comb begin
        neg      = bus.Dado[15];
        abs_val  = neg ? (16'd0 - bus.Dado) : bus.Dado;
        is_min   = (bus.Dado == 16'h8000);
        cap_sign = neg;
        cap_hold = is_min;
        cap_mag  = is_min ? 16'd0 : abs_val;
        cap_bcd  = is_min ? 20'h32768 : 20'd0;
    end
`else
    always_comb begin
        cap_sign = 1'b0;
        cap_hold = 1'b0;
        cap_mag  = bus.Dado;
        cap_bcd  = 20'd0;
    end
`endif

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        bcd_shift = {bcd_adj[18:0], mag[15]};
    end

    // A digit is shown if it or any higher digit is nonzero; units always
    always_comb begin
        for (int i = 0; i < 5; i++)
            nz[i] = (bcd[i*4 +: 4] != 4'd0);
        show[4] = nz[4];
        for (int i = 3; i >= 0; i--)
            show[i] = show[i+1] | nz[i];
        show[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (LEADING_ZERO_BLANK && !show[i])
                seg[i] = SEG_BLANK;
            else
                seg[i] = seg7(bcd[i*4 +: 4]);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.Escrever) state_nxt = SHIFT;
            SHIFT:   if (cnt == 5'd15) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            mag        <= 16'd0;
            bcd        <= 20'd0;
            cnt        <= 5'd0;
            sign       <= 1'b0;
            hold       <= 1'b0;
            bus.Pronto <= 1'b0;
            bus.Hex0   <= SEG_ZERO;
            bus.Hex1   <= SEG_RST;
            bus.Hex2   <= SEG_RST;
            bus.Hex3   <= SEG_RST;
            bus.Hex4   <= SEG_RST;
            bus.Hex5   <= SEG_BLANK;
        end else begin
            bus.Pronto <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.Escrever) begin
                        mag  <= cap_mag;
                        bcd  <= cap_bcd;
                        sign <= cap_sign;
                        hold <= cap_hold;
                        cnt  <= 5'd0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 5'd1;
                    mag <= {mag[14:0], 1'b0};
                    // Preloaded -32768 keeps its BCD; low part is zero
                    if (!hold)
                        bcd <= bcd_shift;
                end
                DONE: begin
                    bus.Hex0   <= seg[0];
                    bus.Hex1   <= seg[1];
                    bus.Hex2   <= seg[2];
                    bus.Hex3   <= seg[3];
                    bus.Hex4   <= seg[4];
                    bus.Hex5   <= sign ? SEG_MINUS : SEG_BLANK;
                    bus.Pronto <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.Ocupado = (state != IDLE);

endmodule

// File: tb/tb_saida_display.sv
// Scoreboard bench for saida_display: expected digits queued at write,
// compared when Pronto fires; second instance covers no-blanking mode.
module tb_saida_display;

`ifdef SAIDA_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    localparam logic [6:0] SEG [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [41:0] RST_HEX =
        {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
    localparam logic [41:0] RST_HEX_NB =
        {7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    typedef struct {
        int          t;
        logic [41:0] hex;
    } exp_t;

    logic Clock;
    logic Reset;
    int   cyc;
    int   errs;
    int   checks;
    int   n_pronto;
    int   n_push;
    exp_t q[$];

    saida_display_if b ();
    saida_display_if b0 ();

    saida_display dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (b)
    );

    saida_display #(.LEADING_ZERO_BLANK(1'b0)) dut_nb (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (b0)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge Clock);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errs = errs + 1;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [41:0] model(input logic [15:0] v,
                                          input bit lzb);
        logic [41:0] r;
        bit          neg;
        int          m;
        int          d [5];
        int          msd;
        neg = SGN && v[15];
        m   = neg ? 65536 - int'(v) : int'(v);
        msd = 0;
        for (int i = 0; i < 5; i++) begin
            d[i] = m % 10;
            m    = m / 10;
            if (d[i] != 0) msd = i;
        end
        for (int i = 0; i < 5; i++)
            r[i*7 +: 7] = (lzb && i > msd) ? 7'h7F : SEG[d[i]];
        r[35 +: 7] = neg ? 7'h3F : 7'h7F;
        return r;
    endfunction

    function automatic logic [41:0] hex_of_b();
        return {b.Hex5, b.Hex4, b.Hex3, b.Hex2, b.Hex1, b.Hex0};
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #2;
            if (b.Pronto === 1'b1) begin
                n_pronto = n_pronto + 1;
                if (q.size() == 0) begin
                    check("spurious_pronto", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("latency", 64'(cyc - e.t), 64'd17);
                    check("hex", 64'(hex_of_b()), 64'(e.hex));
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic write(input logic [15:0] v, input bit expect_it,
                         output int t);
        b.Dado     = v;
        b.Escrever = 1'b1;
        tick();
        t          = cyc;
        b.Escrever = 1'b0;
        if (expect_it) begin
            q.push_back('{t: t, hex: model(v, 1'b1)});
            n_push = n_push + 1;
        end
    endtask

    initial begin
        int t;
        int t0;
        logic [15:0] r;
        errs        = 0;
        checks      = 0;
        n_pronto    = 0;
        n_push      = 0;
        Reset       = 1'b1;
        b.Escrever  = 1'b0;
        b.Dado      = 16'd0;
        b0.Escrever = 1'b0;
        b0.Dado     = 16'd0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        check("rst_ocupado", 64'(b.Ocupado), 64'd0);
        check("rst_pronto", 64'(b.Pronto), 64'd0);
        check("rst_hex", 64'(hex_of_b()), 64'(RST_HEX));
        check("rst_hex_nb",
              64'({b0.Hex5, b0.Hex4, b0.Hex3, b0.Hex2, b0.Hex1, b0.Hex0}),
              64'(RST_HEX_NB));

        // No-blanking instance: 42 shows all five digits
        b0.Dado     = 16'd42;
        b0.Escrever = 1'b1;
        tick();
        t0          = cyc;
        b0.Escrever = 1'b0;
        wait_until(t0 + 16);
        check("nb_pronto_early", 64'(b0.Pronto), 64'd0);
        tick();
        check("nb_pronto", 64'(b0.Pronto), 64'd1);
        check("nb_hex",
              64'({b0.Hex5, b0.Hex4, b0.Hex3, b0.Hex2, b0.Hex1, b0.Hex0}),
              64'({7'h7F, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24}));

        write(16'd1234, 1'b1, t);
        check("busy_after_accept", 64'(b.Ocupado), 64'd1);
        wait_until(t + 16);
        check("busy_in_done", 64'(b.Ocupado), 64'd1);
        tick();
        check("idle_after_done", 64'(b.Ocupado), 64'd0);
        check("hex_1234", 64'(hex_of_b()),
              64'({7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19}));
        tick();
        check("pronto_drop", 64'(b.Pronto), 64'd0);

        write(16'hFFFF, 1'b1, t);
        wait_until(t + 19);
        write(16'h8000, 1'b1, t);
        wait_until(t + 19);
        check("hex_8000", 64'(hex_of_b()),
              64'({SGN ? 7'h3F : 7'h7F, 7'h30, 7'h24, 7'h78, 7'h02, 7'h00}));
        write(16'd0, 1'b1, t);
        wait_until(t + 19);
        check("hold_zero", 64'(hex_of_b()), 64'(RST_HEX));
        for (int i = 0; i < 6; i++) begin
            r = 16'($urandom_range(0, 65535));
            write(r, 1'b1, t);
            wait_until(t + 17);
        end
        tick();

        // Writes during SHIFT and DONE are dropped; T+18 is accepted
        write(16'd555, 1'b1, t0);
        wait_until(t0 + 4);
        write(16'd999, 1'b0, t);
        wait_until(t0 + 16);
        write(16'd999, 1'b0, t);
        check("idle_t17", 64'(b.Ocupado), 64'd0);
        check("hex_555", 64'(hex_of_b()), 64'(model(16'd555, 1'b1)));
        write(16'd999, 1'b1, t);
        check("accept_t18", 64'(t - t0), 64'd18);
        wait_until(t + 19);

        // Reset mid-conversion discards it
        write(16'd777, 1'b0, t0);
        wait_until(t0 + 7);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midrst_ocupado", 64'(b.Ocupado), 64'd0);
        check("midrst_hex", 64'(hex_of_b()), 64'(RST_HEX));
        repeat (20) tick();
        check("midrst_hold", 64'(hex_of_b()), 64'(RST_HEX));
        write(16'd12, 1'b1, t);
        wait_until(t + 19);

        // Reset wins over a simultaneous write
        Reset      = 1'b1;
        b.Escrever = 1'b1;
        b.Dado     = 16'd5;
        tick();
        Reset      = 1'b0;
        b.Escrever = 1'b0;
        check("rst_wins", 64'(b.Ocupado), 64'd0);
        repeat (20) tick();

        check("pronto_count", 64'(n_pronto), 64'(n_push));
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
